// File: rtl/spi_slave_pkg.sv
// SPI slave receiver shared definitions.
// Mode constants, CPOL/CPHA decode and default widths.
package spi_slave_pkg;

  localparam int SPI_MODE0 = 0;
  localparam int SPI_MODE1 = 1;
  localparam int SPI_MODE2 = 2;
  localparam int SPI_MODE3 = 3;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_SYNC_STAGES = 2;

  // Idle level of SCK
  function automatic logic cpol(input int mode);
    return (mode >= 2);
  endfunction

  // Sample on the trailing edge when set
  function automatic logic cpha(input int mode);
    return ((mode % 2) == 1);
  endfunction

  // Sampling happens on rising SCK when CPOL and CPHA agree
  function automatic logic sample_rise(input int mode);
    return (cpol(mode) == cpha(mode));
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// N-stage synchronizer with rise/fall detection.
// Reset loads the idle level so no false edge appears.
module spi_slave_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  // Shift the async input through the chain, keep a delayed copy
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~dly_q;
  assign fall_o = ~q_o & dly_q;

endmodule

// File: rtl/spi_slave_rx.sv
// Receive-only SPI slave, oversampled in the clk domain.
// Optional MISO echo of the previous word: SPI_SLAVE_ECHO_EN.
module spi_slave_rx
  import spi_slave_pkg::*;
#(
  parameter int SPI_MODE    = 1,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  rdy,
  output logic [DATA_WIDTH-1:0] data
`ifdef SPI_SLAVE_ECHO_EN
  ,
  output logic                  miso
`endif
);

  localparam logic CPOL     = cpol(SPI_MODE);
  localparam logic SMP_RISE = sample_rise(SPI_MODE);
  localparam int   CW       = $clog2(DATA_WIDTH + 1);

  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_slave_sync #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(CPOL)
  ) u_sck (
    .clk   (clk),
    .reset (reset),
    .d_i   (sck),
    .q_o   (sck_s),
    .rise_o(sck_rise),
    .fall_o(sck_fall)
  );

  spi_slave_sync #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_cs (
    .clk   (clk),
    .reset (reset),
    .d_i   (cs),
    .q_o   (cs_s),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  spi_slave_sync #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_mosi (
    .clk   (clk),
    .reset (reset),
    .d_i   (mosi),
    .q_o   (mosi_s),
    .rise_o(mosi_rise),
    .fall_o(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sck_s, mosi_rise, mosi_fall, cs_fall};

  logic                  smp_edge;
  logic                  shf_edge;
  logic                  active;
  logic [DATA_WIDTH-1:0] word;

  assign smp_edge = SMP_RISE ? sck_rise : sck_fall;
  assign shf_edge = SMP_RISE ? sck_fall : sck_rise;
  // Stay active one extra cycle after cs rises so a final
  // sample edge coincident with deselect still completes.
  assign active   = ~cs_s | cs_rise;

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rdy_q, rdy_d;

  assign word = {shift_q[DATA_WIDTH-2:0], mosi_s};

  // Receive path next-state
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rdy_d   = 1'b0;
    if (!active) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (smp_edge) begin
      if (cnt_q == CW'(DATA_WIDTH - 1)) begin
        data_d  = word;
        rdy_d   = 1'b1;
        cnt_d   = '0;
        shift_d = '0;
      end else begin
        shift_d = word;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  // Receive path registers
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
    end
  end

  assign rdy  = rdy_q;
  assign data = data_q;

`ifdef SPI_SLAVE_ECHO_EN
  logic [DATA_WIDTH-1:0] tx_q, tx_d;

  // Echo shifter: load on select, advance on non-sample edges
  always_comb begin
    tx_d = tx_q;
    if (cs_fall) begin
      tx_d = data_q;
    end else if (active && smp_edge &&
                 cnt_q == CW'(DATA_WIDTH - 1)) begin
      tx_d = word;
    end else if (active && shf_edge && cnt_q != '0) begin
      tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
    end
  end

  // Echo shifter register
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_q <= '0;
    end else begin
      tx_q <= tx_d;
    end
  end

  assign miso = ~cs_s & tx_q[DATA_WIDTH-1];
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx, mode 1, 8-bit.
// Scoreboard queue of expected words, popped on each rdy.
module tb_spi_slave_rx;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       sck   = 1'b0;
  logic       cs    = 1'b1;
  logic       mosi  = 1'b0;
  logic       rdy;
  logic [7:0] data;
`ifdef SPI_SLAVE_ECHO_EN
  logic       miso;
`endif

  spi_slave_rx #(
    .SPI_MODE   (1),
    .DATA_WIDTH (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sck  (sck),
    .cs   (cs),
    .mosi (mosi),
    .rdy  (rdy),
    .data (data)
`ifdef SPI_SLAVE_ECHO_EN
    ,
    .miso (miso)
`endif
  );

  always #5 clk = ~clk;

  int         checks    = 0;
  int         failures  = 0;
  int         pulses    = 0;
  int         exp_total = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_exp  = 8'h00;
  logic [7:0] echo_bits = 8'h00;
  logic       rdy_prev  = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every rdy pops one expected word
  always @(negedge clk) begin
    if (rdy === 1'b1) begin
      check("rdy_width", {31'd0, rdy_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        check("spurious_rdy", {31'd0, rdy}, 32'd0);
      end else begin
        check("data", {24'd0, data}, {24'd0, exp_q.pop_front()});
      end
      pulses <= pulses + 1;
    end
    rdy_prev <= rdy;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 1: drive on rising SCK, slave samples on falling
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sck  = 1'b1;
      mosi = b[7-i];
      clks(2);
      sck  = 1'b0;
      clks(2);
`ifdef SPI_SLAVE_ECHO_EN
      echo_bits = {echo_bits[6:0], miso};
`endif
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_q.push_back(b);
    last_exp = b;
    exp_total++;
    send_bits(b, 8);
  endtask

  task automatic frame(input logic [7:0] b);
    cs = 1'b0;
    clks(2);
    send_byte(b);
    clks(2);
    cs = 1'b1;
    clks(6);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) clks(1);
    check(tag, exp_q.size(), 32'd0);
  endtask

  logic [7:0] frames [8] = '{8'h55, 8'h00, 8'h23, 8'h00,
                             8'hFF, 8'h00, 8'h00, 8'hA4};

  initial begin
    // Reset holds outputs at zero
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_rdy", {31'd0, rdy}, 32'd0);
      check("rst_data", {24'd0, data}, 32'd0);
    end
    reset = 1'b0;
    clks(10);
    check("post_rst_data", {24'd0, data}, 32'd0);

    // Single byte
    frame(8'h55);
    drain("drain_55");
    check("hold_55", {24'd0, data}, 32'h55);

    // Eight separate frames
    foreach (frames[i]) begin
      frame(frames[i]);
      drain("drain_seq");
      check("hold_seq", {24'd0, data}, {24'd0, last_exp});
    end
    clks(20);
    check("idle_hold", {24'd0, data}, 32'hA4);

    // Aborted partial word is discarded
    cs = 1'b0;
    clks(2);
    send_bits(8'hFF, 5);
    clks(2);
    cs = 1'b1;
    clks(8);
    check("abort_hold", {24'd0, data}, 32'hA4);
    // SCK toggling while deselected is ignored
    send_bits(8'hFF, 8);
    clks(6);
    check("desel_hold", {24'd0, data}, 32'hA4);
    frame(8'h23);
    drain("drain_23");
    check("hold_23", {24'd0, data}, 32'h23);

    // Two words in one frame
    cs = 1'b0;
    clks(2);
    send_byte(8'hA4);
    send_byte(8'h5A);
    clks(2);
    cs = 1'b1;
    clks(6);
    drain("drain_b2b");
    check("hold_5a", {24'd0, data}, 32'h5A);

    // cs rises together with the final sample edge
    cs = 1'b0;
    clks(2);
    exp_q.push_back(8'hC3);
    last_exp = 8'hC3;
    exp_total++;
    send_bits(8'hC3, 7);
    sck  = 1'b1;
    mosi = 1'b1;
    clks(2);
    sck  = 1'b0;
    cs   = 1'b1;
    clks(8);
    drain("drain_cs_edge");
    check("hold_c3", {24'd0, data}, 32'hC3);
    check("pulses", pulses, exp_total);

    // Reset mid-word
    cs = 1'b0;
    clks(2);
    send_bits(8'hF0, 4);
    reset = 1'b1;
    cs    = 1'b1;
    clks(2);
    check("midrst_data", {24'd0, data}, 32'd0);
    check("midrst_rdy", {31'd0, rdy}, 32'd0);
    reset = 1'b0;
    clks(6);
    check("midrst_hold", {24'd0, data}, 32'd0);

`ifdef SPI_SLAVE_ECHO_EN
    check("miso_idle", {31'd0, miso}, 32'd0);
    frame(8'h23);
    drain("drain_e1");
    echo_bits = 8'h00;
    frame(8'h55);
    drain("drain_e2");
    check("echo", {24'd0, echo_bits}, 32'h23);
    check("miso_desel", {31'd0, miso}, 32'd0);
`endif

    check("pulses_end", pulses, exp_total);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
